dram_read_streamer: RTL and testbench

DRAM_READ_STREAMER -- requirements
Module: dram_read_streamer

---
 rtl/dram_read_streamer.sv | 173 +++++++++++++++++
 tb/tb_dram_read_streamer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_streamer.sv
// rtl/dram_read_streamer.sv - streams DRAM 512-bit lines out as 128-bit PCIe beats
// Optional statistics counters are built only when DRAM_READ_STREAMER_STATS_EN is defined.
package dram_read_streamer_pkg;
    typedef struct packed {
        logic         valid;
        logic         isWrite;
        logic [63:0]  addr;
        logic [511:0] data;
    } MemReq;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } MemResp;

    typedef struct packed {
        logic         valid;
        logic         last;
        logic [15:0]  slot;
        logic [13:0]  pad;
        logic [127:0] data;
    } PCIEPacket;
endpackage

module dram_read_streamer
    import dram_read_streamer_pkg::*;
#(
    parameter int RESP_LOG_DEPTH = 3,
    parameter int MAX_LINES_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [63:0]            cmd_addr,
    input  logic [MAX_LINES_W-1:0] cmd_lines,
    input  logic [15:0]            cmd_slot,
    output logic                   cmd_ready,
    output MemReq                  mem_req_out,
    input  logic                   mem_req_grant_in,
    input  MemResp                 mem_resp_in,
    output logic                   mem_resp_grant_out,
    output PCIEPacket              pcie_packet_out,
    input  logic                   pcie_grant_in,
    output logic                   busy,
    output logic [31:0]            stat_lines,
    output logic [31:0]            stat_stalls
);
    localparam int                        DEPTH    = 1 << RESP_LOG_DEPTH;
    localparam logic [MAX_LINES_W-1:0]    LINE_ONE = MAX_LINES_W'(1);
    localparam logic [RESP_LOG_DEPTH-1:0] PTR_ONE  = RESP_LOG_DEPTH'(1);
    localparam logic [RESP_LOG_DEPTH:0]   CNT_ONE  = (RESP_LOG_DEPTH + 1)'(1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
    state_t state_q, state_d;

    logic [63:0]               addr_q;
    logic [MAX_LINES_W-1:0]    lines_q, issued_q, emitted_q, inflight;
    logic [15:0]               slot_q;
    logic [1:0]                beat_q;
    logic [RESP_LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [RESP_LOG_DEPTH:0]   count_q;
    logic [511:0]              buf_q [DEPTH];

    logic cmd_fire, req_valid, req_fire, resp_fire;
    logic beat_valid, beat_fire, line_done, last_line;

    // A line holds a credit from request issue until its last beat leaves, so the buffer never overflows.
    assign inflight   = issued_q - emitted_q;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign req_valid  = (state_q == STREAM) && (issued_q < lines_q) && (32'(inflight) < DEPTH);
    assign req_fire   = req_valid && mem_req_grant_in;
    assign resp_fire  = !rst && (state_q == STREAM) && mem_resp_in.valid;
    assign beat_valid = (state_q == STREAM) && (count_q != '0);
    assign beat_fire  = beat_valid && pcie_grant_in;
    assign line_done  = beat_fire && (beat_q == 2'd3);
    assign last_line  = (emitted_q == lines_q - LINE_ONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire && (cmd_lines != '0)) state_d = STREAM;
            STREAM:  if (line_done && last_line) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready          = 1'b0;
        busy               = 1'b0;
        mem_req_out        = '0;
        mem_resp_grant_out = 1'b0;
        pcie_packet_out    = '0;
        if (!rst) begin
            cmd_ready          = (state_q == IDLE);
            busy               = (state_q != IDLE);
            mem_resp_grant_out = mem_resp_in.valid;
            mem_req_out.valid  = req_valid;
            mem_req_out.addr   = addr_q;
            if (beat_valid) begin
                pcie_packet_out.valid = 1'b1;
                pcie_packet_out.data  = buf_q[rd_ptr_q][{beat_q, 7'd0} +: 128];
                pcie_packet_out.slot  = slot_q;
                pcie_packet_out.last  = (beat_q == 2'd3) && last_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            lines_q   <= '0;
            slot_q    <= '0;
            issued_q  <= '0;
            emitted_q <= '0;
            beat_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else if (cmd_fire) begin
            addr_q    <= cmd_addr & ~64'h3F;
            lines_q   <= cmd_lines;
            slot_q    <= cmd_slot;
            issued_q  <= '0;
            emitted_q <= '0;
            beat_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (req_fire) begin
                addr_q   <= addr_q + 64'd64;
                issued_q <= issued_q + LINE_ONE;
            end
            if (resp_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (beat_fire) beat_q <= beat_q + 2'd1;
            if (line_done) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                emitted_q <= emitted_q + LINE_ONE;
            end
            if (resp_fire && !line_done)      count_q <= count_q + CNT_ONE;
            else if (!resp_fire && line_done) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_fire) buf_q[wr_ptr_q] <= mem_resp_in.data;
    end

`ifdef DRAM_READ_STREAMER_STATS_EN
    logic [31:0] stat_lines_q, stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lines_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (line_done) stat_lines_q <= stat_lines_q + 32'd1;
            if (beat_valid && !pcie_grant_in) stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_lines  = stat_lines_q;
    assign stat_stalls = stat_stalls_q;
`else
    assign stat_lines  = '0;
    assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_dram_read_streamer.sv
// tb/tb_dram_read_streamer.sv - randomized scoreboard bench for dram_read_streamer
module tb_dram_read_streamer;
    import dram_read_streamer_pkg::*;

`ifdef DRAM_READ_STREAMER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [63:0] cmd_addr = '0;
    logic [15:0] cmd_lines = '0;
    logic [15:0] cmd_slot = '0;
    logic        cmd_ready;
    MemReq       mem_req_out;
    logic        mem_req_grant_in = 1'b0;
    MemResp      mem_resp_in = '0;
    logic        mem_resp_grant_out;
    PCIEPacket   pcie_packet_out;
    logic        pcie_grant_in = 1'b0;
    logic        busy;
    logic [31:0] stat_lines, stat_stalls;

    dram_read_streamer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_lines(cmd_lines), .cmd_slot(cmd_slot),
        .cmd_ready(cmd_ready),
        .mem_req_out(mem_req_out), .mem_req_grant_in(mem_req_grant_in),
        .mem_resp_in(mem_resp_in), .mem_resp_grant_out(mem_resp_grant_out),
        .pcie_packet_out(pcie_packet_out), .pcie_grant_in(pcie_grant_in),
        .busy(busy), .stat_lines(stat_lines), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] data; logic [15:0] slot; logic last; } beat_t;
    typedef struct { logic [63:0] addr; int ready; } pend_t;

    beat_t       exp_beats[$];
    logic [63:0] exp_addrs[$];
    pend_t       pend[$];

    int checks = 0, errors = 0;
    int cyc = 0, req_cnt = 0, beat_cnt = 0, req_valid_cycles = 0, pcie_valid_cycles = 0;
    int req_mode = 0, pcie_mode = 0;        // 0 random, 1 always grant, 2 never grant
    int stall_target = 0, stalls_done = 0;
    bit resp_force = 1'b1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory contents: every 64-bit word depends on the line address and its position.
    function automatic logic [511:0] pat(input logic [63:0] a);
        logic [511:0] p;
        for (int j = 0; j < 8; j++)
            p[64*j +: 64] = {a[31:0] ^ (32'h1357_9BDF * 32'(j + 1)), a[63:32] + 32'(j * 3 + 1)};
        return p;
    endfunction

    // Environment: drives grants and memory responses, and scores every handshake.
    always begin
        bit          prev_req_wait, prev_pcie_wait, from_pend;
        logic [63:0] prev_addr;
        PCIEPacket   prev_pkt;
        beat_t       eb;
        int          rdy;
        @(negedge clk);
        cyc++;
        mem_req_grant_in = (req_mode == 1) || (req_mode == 0 && $urandom_range(0, 3) != 0);
        pcie_grant_in = (stalls_done >= stall_target) &&
                        ((pcie_mode == 1) || (pcie_mode == 0 && $urandom_range(0, 2) != 0));
        from_pend = 1'b0;
        if (resp_force) begin
            mem_resp_in.valid = 1'b1;
            mem_resp_in.data  = '1;
        end else if (pend.size() != 0 && pend[0].ready <= cyc) begin
            mem_resp_in.valid = 1'b1;
            mem_resp_in.data  = pat(pend[0].addr);
            from_pend = 1'b1;
        end else begin
            mem_resp_in = '0;
        end
        #1;
        if (rst) begin
            prev_req_wait = 1'b0;
            prev_pcie_wait = 1'b0;
            exp_beats.delete();
            exp_addrs.delete();
        end else begin
            if (from_pend && mem_resp_grant_out) void'(pend.pop_front());

            if (mem_req_out.valid) begin
                req_valid_cycles++;
                if (prev_req_wait) chk("req_hold_addr", mem_req_out.addr, prev_addr);
                if (mem_req_grant_in) begin
                    req_cnt++;
                    chk("req_expected", exp_addrs.size() != 0, 1);
                    if (exp_addrs.size() != 0) chk("req_addr", mem_req_out.addr, exp_addrs.pop_front());
                    chk("req_rw_data", {mem_req_out.isWrite, |mem_req_out.data}, 0);
                    rdy = cyc + int'($urandom_range(1, 6));
                    if (pend.size() != 0 && pend[$].ready > rdy) rdy = pend[$].ready;
                    pend.push_back('{addr: mem_req_out.addr, ready: rdy});
                    prev_req_wait = 1'b0;
                end else begin
                    prev_req_wait = 1'b1;
                    prev_addr = mem_req_out.addr;
                end
            end else begin
                if (prev_req_wait) chk("req_held_valid", mem_req_out.valid, 1);
                prev_req_wait = 1'b0;
            end

            if (pcie_packet_out.valid) begin
                pcie_valid_cycles++;
                if (prev_pcie_wait) chk("beat_hold", pcie_packet_out, prev_pkt);
                if (pcie_grant_in) begin
                    beat_cnt++;
                    chk("beat_expected", exp_beats.size() != 0, 1);
                    if (exp_beats.size() != 0) begin
                        eb = exp_beats.pop_front();
                        chk("beat_data", pcie_packet_out.data, eb.data);
                        chk("beat_slot", pcie_packet_out.slot, eb.slot);
                        chk("beat_last", pcie_packet_out.last, eb.last);
                        chk("beat_pad", pcie_packet_out.pad, 0);
                    end
                    prev_pcie_wait = 1'b0;
                end else begin
                    prev_pcie_wait = 1'b1;
                    prev_pkt = pcie_packet_out;
                    if (stalls_done < stall_target) stalls_done++;
                end
            end else begin
                if (prev_pcie_wait) chk("beat_held_valid", pcie_packet_out.valid, 1);
                prev_pcie_wait = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic [63:0] a, input int n, input logic [15:0] s);
        int          w;
        logic [63:0] la;
        logic [511:0] p;
        beat_t       b;
        w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_lines = 16'(n);
        cmd_slot  = s;
        #2;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk("cmd_accept", cmd_ready, 1);
        for (int i = 0; i < n; i++) begin
            la = (a & ~64'h3F) + 64'(i) * 64'd64;
            exp_addrs.push_back(la);
            p = pat(la);
            for (int k = 0; k < 4; k++) begin
                b.data = p[128*k +: 128];
                b.slot = s;
                b.last = (i == n - 1) && (k == 3);
                exp_beats.push_back(b);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        bit ok;
        w = 0;
        ok = 1'b0;
        while (!ok && w < budget) begin
            @(negedge clk);
            #2;
            ok = (exp_beats.size() == 0) && (exp_addrs.size() == 0) && !busy;
            w++;
        end
        chk("idle_reached", ok, 1);
    endtask

    initial begin
        int r0, b0, v0, p0, w, busy_seen;

        repeat (3) @(negedge clk);
        #2;
        chk("reset_ctrl", {cmd_ready, busy, mem_resp_grant_out, mem_req_out.valid}, 0);
        chk("reset_pcie", pcie_packet_out, 0);
        chk("reset_stats", {stat_lines, stat_stalls}, 0);
        @(negedge clk);
        resp_force = 1'b0;
        rst = 1'b0;
        #2;
        chk("idle_ready", {cmd_ready, busy}, 2'b10);

        // Single line with a known pattern.
        r0 = req_cnt; b0 = beat_cnt;
        send_cmd(64'h1000, 1, 16'd5);
        wait_idle(500);
        chk("single_reqs", req_cnt - r0, 1);
        chk("single_beats", beat_cnt - b0, 4);
        chk("single_busy_done", busy, 0);

        // Zero-length command: accepted, nothing happens.
        r0 = req_valid_cycles; p0 = pcie_valid_cycles; busy_seen = 0;
        send_cmd(64'h2000, 0, 16'd7);
        repeat (10) begin
            @(negedge clk);
            #2;
            if (busy) busy_seen++;
        end
        chk("zero_busy", busy_seen, 0);
        chk("zero_reqs", req_valid_cycles - r0, 0);
        chk("zero_beats", pcie_valid_cycles - p0, 0);

        // Address wrap at the top of the 64-bit space.
        r0 = req_cnt;
        send_cmd(64'hFFFF_FFFF_FFFF_FFC0, 2, 16'h00A9);
        wait_idle(500);
        chk("wrap_reqs", req_cnt - r0, 2);

        // Credit limit: PCIe stalled, memory always granting.
        req_mode = 1; pcie_mode = 2;
        r0 = req_cnt; b0 = beat_cnt;
        send_cmd(64'h0004_0000, 20, 16'h1234);
        repeat (40) @(negedge clk);
        #2;
        chk("credit_reqs", req_cnt - r0, 8);
        pcie_mode = 1;
        wait_idle(2000);
        chk("credit_total_reqs", req_cnt - r0, 20);
        chk("credit_total_beats", beat_cnt - b0, 80);

        // Random commands, random grants and memory latency.
        req_mode = 0; pcie_mode = 0;
        for (int t = 0; t < 6; t++) begin
            b0 = beat_cnt;
            v0 = int'($urandom_range(1, 12));
            send_cmd({$urandom, $urandom}, v0, 16'($urandom));
            wait_idle(3000);
            chk("rand_beats", beat_cnt - b0, 4 * v0);
        end

        // Reset in the middle of a transfer.
        b0 = beat_cnt; w = 0;
        send_cmd({$urandom, $urandom}, 10, 16'h0BEE);
        while (beat_cnt - b0 < 12 && w < 2000) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk("midrst_progress", beat_cnt - b0 >= 12, 1);
        pcie_mode = 2;
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrst_ctrl", {cmd_ready, busy, mem_resp_grant_out, mem_req_out.valid}, 0);
        chk("midrst_pcie", pcie_packet_out, 0);
        @(negedge clk);
        #2;
        chk("midrst_ctrl_next", {cmd_ready, busy, mem_resp_grant_out, mem_req_out.valid}, 0);
        chk("midrst_pcie_next", pcie_packet_out, 0);
        chk("midrst_stats", {stat_lines, stat_stalls}, 0);
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        while (pend.size() != 0 && w < 200) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk("late_resp_drained", pend.size(), 0);
        chk("late_resp_idle", {busy, pcie_packet_out.valid}, 0);

        // Fresh command after reset with a fixed number of stalled beat cycles.
        pcie_mode = 1;
        stall_target = stalls_done + 7;
        b0 = beat_cnt;
        send_cmd(64'h0000_0ABC_0000_0040, 2, 16'h0042);
        wait_idle(500);
        chk("post_rst_beats", beat_cnt - b0, 8);
        chk("stat_lines", stat_lines, STATS_ON ? 32'd2 : 32'd0);
        chk("stat_stalls", stat_stalls, STATS_ON ? 32'd7 : 32'd0);

        chk("beats_left", exp_beats.size(), 0);
        chk("addrs_left", exp_addrs.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
